twos_comp_deser: RTL and testbench
==================================

TWOS_COMP_DESER -- requirements
Module: twos_comp_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the frame length in bits (legal range 2..32).
REQ-002 The block SHALL have input t_clock, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have input r, 1 bit, the reset: asynchronous, active-high.
REQ-004 The block SHALL have input x, 1 bit, the serial two's-complemented data bit, LSB first.
REQ-005 The block SHALL have input x_valid, 1 bit; x is sampled only on edges where x_valid=1.
REQ-006 The block SHALL have input x_first, 1 bit, qualified by x_valid, marking the LSB of a frame.
REQ-007 The block SHALL have output word, WIDTH bits, the recovered (re-complemented) parallel word.
REQ-008 The block SHALL have output word_valid, 1 bit, a one-cycle pulse when word updates.
REQ-009 The block SHALL have output busy, 1 bit, high while a frame is partially received.
REQ-010 The block SHALL have output frame_err, 1 bit, a one-cycle pulse on a malformed frame.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 In IDLE, a sample with x_first=1 SHALL start a frame (bit 0) and move to SHIFT; samples with x_first=0 SHALL be ignored.
REQ-013 Decoding SHALL be on the fly: out_bit = seen_one ? ~x : x; seen_one SHALL clear at frame start and set after the first sampled x=1.
REQ-014 out_bit SHALL be shifted into a WIDTH-bit register at position = bit counter; the counter SHALL run 0..WIDTH-1.
REQ-015 Edges with x_valid=0 SHALL hold all state (gaps allowed anywhere mid-frame).
REQ-016 On the edge sampling bit WIDTH-1, word SHALL load the assembled value, word_valid SHALL be high for the following cycle only, and the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be exactly 0 cycles from the last-bit edge to word/word_valid becoming visible.
REQ-018 word SHALL hold its value between frames.
REQ-019 x_first=1 sampled in SHIFT SHALL pulse frame_err for one cycle, discard the partial frame, and restart with this bit as bit 0 (no word_valid).
REQ-020 A frame whose bit WIDTH-1 carries x_first=1 SHALL be treated per REQ-019, not completed.
REQ-021 busy SHALL be 1 exactly while the state is SHIFT.
REQ-022 Back-to-back frames SHALL be accepted: x_first on the edge after the completing edge SHALL start a new frame with no gap cycle.

Reset
REQ-023 Asserting r SHALL immediately force: state=IDLE, counter=0, seen_one=0, word=0, word_valid=0, busy=0, frame_err=0 (and ovf=0 when present).
REQ-024 Reset mid-frame SHALL discard the partial frame without word_valid or frame_err.
REQ-025 After r deasserts, the first sample SHALL be accepted on the next rising edge.

Configuration
REQ-026 The macro SHALL be TWOS_DESER_OVF_EN.
REQ-027 When TWOS_DESER_OVF_EN is defined, the block SHALL add output ovf, 1 bit, valid with word_valid: 1 iff the recovered word = 1 followed by WIDTH-1 zeros (no representable negation).
REQ-028 When TWOS_DESER_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-029 The bench SHALL drive bits 0,1,0,1,1,1,1,1 (0xFA, x_first on the first bit); it SHALL check word=0x06 and a single word_valid pulse.
REQ-030 The bench SHALL drive 0xFF with x_valid gaps of 3 cycles between bits; it SHALL check word=0x01, and busy=1 from bit 0 until the completing edge.
REQ-031 The bench SHALL drive 0x80; it SHALL check word=0x80 with ovf=1 (OVF_EN defined) and drive 0x00 -> word=0x00, ovf=0.
REQ-032 The bench SHALL drive 4 bits then assert x_first; it SHALL check a frame_err pulse, no word_valid, and a correct word after 8 further bits.
REQ-033 The bench SHALL assert r after 5 bits; it SHALL check all outputs=0 immediately, and that the next complete frame decodes correctly.
REQ-034 The bench SHALL drive two back-to-back frames 0xFA, 0x01; it SHALL check word_valid pulses 8 sample-edges apart with words 0x06 then 0xFF.

Source files
------------

// File: rtl/twos_comp_deser.sv
// -----------------------------------------------------------------------------
// twos_comp_deser
//
// Serial-to-parallel deserialiser for a two's-complemented bit stream. The
// serial data is the two's complement of the original word, sent LSB first.
// The original word is rebuilt on the fly with the copy-until-first-one rule:
// bits up to and including the first 1 pass through unchanged, and every bit
// after that is inverted.
//
// Parameters
//   WIDTH       frame length in bits (2..32), default 8
//
// Ports
//   t_clock     in   clock; all state updates on its rising edge
//   r           in   asynchronous active-high reset
//   x           in   serial data bit, LSB first
//   x_valid     in   sample qualifier; edges with x_valid=0 hold all state
//   x_first     in   marks the LSB (bit 0) of a frame, qualified by x_valid
//   word        out  recovered parallel word, held between frames
//   word_valid  out  one-cycle pulse when word updates
//   busy        out  high while a frame is partially received
//   frame_err   out  one-cycle pulse when x_first arrives mid-frame
//   ovf         out  (only with TWOS_DESER_OVF_EN) set when the recovered word
//                    is the most negative value (1 followed by zeros), which
//                    has no representable negation; valid with word_valid
//
// Configuration macro
//   TWOS_DESER_OVF_EN  when defined, adds the ovf output and its logic.
// -----------------------------------------------------------------------------
module twos_comp_deser #(
  parameter int WIDTH = 8
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic             x,
  input  logic             x_valid,
  input  logic             x_first,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             busy,
  output logic             frame_err
`ifdef TWOS_DESER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             seen_one_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] word_r;
  logic             word_valid_r;
  logic             busy_r;
  logic             frame_err_r;

  logic             out_bit_s;
  logic [WIDTH-1:0] assembled_s;
  logic [WIDTH-1:0] start_word_s;
  logic             start_s;
  logic             restart_s;
  logic             complete_s;

`ifdef TWOS_DESER_OVF_EN
  logic             ovf_r;

  // True for the single value whose negation is not representable.
  function automatic logic is_most_negative(input logic [WIDTH-1:0] v);
    return (v == {1'b1, {(WIDTH-1){1'b0}}});
  endfunction
`endif

  // Decode the current serial bit and classify the sample edge.
  always_comb begin
    out_bit_s    = 1'b0;
    assembled_s  = shreg_r;
    start_word_s = {{(WIDTH-1){1'b0}}, x};
    start_s      = 1'b0;
    restart_s    = 1'b0;
    complete_s   = 1'b0;

    // Before the first 1 the bit passes through; afterwards it is inverted.
    if (seen_one_r) begin
      out_bit_s = ~x;
    end else begin
      out_bit_s = x;
    end

    // Value of the word if the current bit were written at the counter.
    assembled_s[cnt_r] = out_bit_s;

    if (x_valid) begin
      case (state_r)
        IDLE: begin
          start_s = x_first;
        end
        SHIFT: begin
          // x_first always wins, even on what would be the last bit.
          if (x_first) begin
            restart_s = 1'b1;
          end else begin
            complete_s = (cnt_r == CNT_LAST);
          end
        end
        default: begin
          start_s = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  // Frame FSM: IDLE waits for x_first, SHIFT assembles bits 1..WIDTH-1.
  always_ff @(posedge t_clock or posedge r) begin
    if (r) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      seen_one_r   <= 1'b0;
      shreg_r      <= {WIDTH{1'b0}};
      word_r       <= {WIDTH{1'b0}};
      word_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (start_s || restart_s) begin
        // Bit 0 of a new frame: seen_one starts clear, so the bit passes
        // through and the shift register restarts from this bit alone.
        state_r     <= SHIFT;
        busy_r      <= 1'b1;
        cnt_r       <= CNT_ONE;
        seen_one_r  <= x;
        shreg_r     <= start_word_s;
        frame_err_r <= restart_s;
      end else if (complete_s) begin
        state_r      <= IDLE;
        busy_r       <= 1'b0;
        cnt_r        <= CNT_ZERO;
        seen_one_r   <= 1'b0;
        shreg_r      <= {WIDTH{1'b0}};
        word_r       <= assembled_s;
        word_valid_r <= 1'b1;
      end else if (x_valid && (state_r == SHIFT)) begin
        cnt_r      <= cnt_r + CNT_ONE;
        seen_one_r <= seen_one_r | x;
        shreg_r    <= assembled_s;
      end else begin
        // No qualified sample (or x_first=0 in IDLE): hold.
        state_r <= state_r;
      end
    end
  end

`ifdef TWOS_DESER_OVF_EN
  // Overflow flag, updated together with word and held alongside it.
  always_ff @(posedge t_clock or posedge r) begin
    if (r) begin
      ovf_r <= 1'b0;
    end else if (complete_s) begin
      ovf_r <= is_most_negative(assembled_s);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign word       = word_r;
  assign word_valid = word_valid_r;
  assign busy       = busy_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_twos_comp_deser.sv
module tb_twos_comp_deser;

  localparam int W = 8;

  logic         t_clock = 1'b0;
  logic         r;
  logic         x;
  logic         x_valid;
  logic         x_first;
  logic [W-1:0] word;
  logic         word_valid;
  logic         busy;
  logic         frame_err;
`ifdef TWOS_DESER_OVF_EN
  logic         ovf;
`endif

  twos_comp_deser #(.WIDTH(W)) dut (
    .t_clock    (t_clock),
    .r          (r),
    .x          (x),
    .x_valid    (x_valid),
    .x_first    (x_first),
    .word       (word),
    .word_valid (word_valid),
    .busy       (busy),
    .frame_err  (frame_err)
`ifdef TWOS_DESER_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 t_clock = ~t_clock;

  typedef struct {
    logic [7:0] tx;       // serial (complemented) value
    logic [7:0] exp_word; // recovered word
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_cnt = 0;
  int   wv_log[$];        // edge numbers on which word_valid was seen

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one edge's inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic b, input logic f);
    @(negedge t_clock);
    x_valid = v;
    x       = b;
    x_first = f;
    @(posedge t_clock);
    edge_cnt++;
    #1;
    if (word_valid === 1'b1) wv_log.push_back(edge_cnt);
  endtask

  // Send a full frame with x_first on bit 0; check busy/word_valid per bit.
  task automatic send_frame(input logic [7:0] tx, input logic [7:0] exp, input logic exp_err,
                            input string tag);
    for (int i = 0; i < W; i++) begin
      step(1'b1, tx[i], (i == 0));
      if (i == 0) check({tag, "_err_bit0"}, frame_err, exp_err);
      if (i < W - 1) begin
        check({tag, "_busy_mid"}, busy, 1'b1);
        check({tag, "_wv_mid"}, word_valid, 1'b0);
      end
    end
    check({tag, "_word"}, word, exp);
    check({tag, "_wv_end"}, word_valid, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_err_end"}, frame_err, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'hFA, 8'h06, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h01, 8'hFF, 1'b0};
    vecs[5] = '{8'h7F, 8'h81, 1'b0};
    vecs[6] = '{8'h55, 8'hAB, 1'b0};
    vecs[7] = '{8'h02, 8'hFE, 1'b0};

    r = 1'b1; x = 1'b0; x_valid = 1'b0; x_first = 1'b0;
    @(posedge t_clock); @(posedge t_clock); #1;
    check("rst_word", word, 8'h00);
    check("rst_wv", word_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", frame_err, 1'b0);
    @(negedge t_clock); r = 1'b0;

    // Samples without x_first in IDLE are ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    check("idle_ignore_busy", busy, 1'b0);
    check("idle_ignore_wv", word_valid, 1'b0);
    check("idle_ignore_word", word, 8'h00);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      wv_log.delete();
      send_frame(vecs[v].tx, vecs[v].exp_word, 1'b0, $sformatf("vec%0d", v));
`ifdef TWOS_DESER_OVF_EN
      check($sformatf("vec%0d_ovf", v), ovf, vecs[v].exp_ovf);
`endif
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_wv_drop", v), word_valid, 1'b0);
      check($sformatf("vec%0d_word_hold", v), word, vecs[v].exp_word);
      check($sformatf("vec%0d_wv_count", v), wv_log.size(), 1);
    end

    // 0xFF with 3 idle cycles between bits.
    wv_log.delete();
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b1, (i == 0));
      if (i < W - 1) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b0);
          check("gap_busy", busy, 1'b1);
          check("gap_wv", word_valid, 1'b0);
        end
      end
    end
    check("gap_word", word, 8'h01);
    check("gap_wv_end", word_valid, 1'b1);
    check("gap_busy_end", busy, 1'b0);
    check("gap_wv_count", wv_log.size(), 1);

    // 4 bits then x_first: frame_err, restart with 0x55 -> 0xAB.
    wv_log.delete();
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 8'hAB, 1'b1, "err4");
    check("err4_wv_count", wv_log.size(), 1);

    // x_first on what would be bit 7: error, not completion.
    wv_log.delete();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < W - 1; i++) step(1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 8'hFE, 1'b1, "err7");
    check("err7_wv_count", wv_log.size(), 1);
    step(1'b0, 1'b0, 1'b0);
    check("err7_err_drop", frame_err, 1'b0);

    // Reset after 5 bits: outputs clear immediately, next frame decodes.
    wv_log.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0));
    @(negedge t_clock);
    x_valid = 1'b0;
    r = 1'b1;
    #1;
    check("mid_rst_word", word, 8'h00);
    check("mid_rst_wv", word_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", frame_err, 1'b0);
`ifdef TWOS_DESER_OVF_EN
    check("mid_rst_ovf", ovf, 1'b0);
`endif
    @(negedge t_clock);
    r = 1'b0; x_valid = 1'b1; x = 1'b1; x_first = 1'b1;
    @(posedge t_clock); edge_cnt++; #1;
    check("post_rst_first_busy", busy, 1'b1);
    for (int i = 1; i < W; i++) step(1'b1, 1'b0, 1'b0);
    check("post_rst_word", word, 8'hFF);
    check("post_rst_wv", word_valid, 1'b1);
    check("post_rst_wv_count", wv_log.size(), 1);

    // Back-to-back frames 0xFA then 0x01.
    step(1'b0, 1'b0, 1'b0);
    wv_log.delete();
    send_frame(8'hFA, 8'h06, 1'b0, "b2b_a");
    send_frame(8'h01, 8'hFF, 1'b0, "b2b_b");
    check("b2b_wv_count", wv_log.size(), 2);
    if (wv_log.size() == 2) check("b2b_spacing", wv_log[1] - wv_log[0], 8);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_word_hold", word, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
